// File: rtl/gshare_inflight_predictor_if.sv
// Fetch/resolve bundle between the front end and the gshare in-flight predictor.
interface gshare_inflight_predictor_if #(
    parameter int unsigned CNT_WIDTH = 2,
    parameter int unsigned OCC_WIDTH = 3
);
    logic                 stall;
    logic                 fetch_valid;
    logic [31:0]          fetch_pc;
    logic                 ready;
    logic                 pred_taken;
    logic [CNT_WIDTH-1:0] pred_count;
    logic                 resolve_valid;
    logic                 resolve_taken;
    logic                 mispredict;
    logic [OCC_WIDTH-1:0] inflight;
    logic                 err_underflow;

    modport master (
        output stall, fetch_valid, fetch_pc, resolve_valid, resolve_taken,
        input  ready, pred_taken, pred_count, mispredict, inflight, err_underflow
    );

    modport slave (
        input  stall, fetch_valid, fetch_pc, resolve_valid, resolve_taken,
        output ready, pred_taken, pred_count, mispredict, inflight, err_underflow
    );
endinterface

// File: rtl/gshare_inflight_predictor.sv
// Gshare/bimodal direction predictor with a hardware init sweep and an in-order
// queue of unresolved predictions that restores speculative history on mispredict.
module gshare_inflight_predictor #(
    parameter int unsigned CNT_WIDTH    = 2,
    parameter int unsigned CNT_INIT     = 1,
    parameter int unsigned IDX_WIDTH    = 6,
    parameter int unsigned HIST_WIDTH   = 6,
    parameter int unsigned HASH_MODE    = 1,
    parameter int unsigned MAX_INFLIGHT = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    gshare_inflight_predictor_if.slave  bus
);

    localparam int unsigned DEPTH = 2 ** IDX_WIDTH;
    localparam int unsigned PTR_W = $clog2(MAX_INFLIGHT);
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;
    localparam logic [IDX_WIDTH-1:0] SWEEP_LAST = '1;

    typedef enum logic {ST_INIT, ST_RUN} state_e;

    typedef struct packed {
        logic [IDX_WIDTH-1:0]  idx;
        logic [CNT_WIDTH-1:0]  cnt;
        logic [HIST_WIDTH-1:0] hist;
    } entry_t;

    logic [CNT_WIDTH-1:0]  table_q [DEPTH];
    entry_t                queue_q [MAX_INFLIGHT];

    state_e                state_q, state_d;
    logic [IDX_WIDTH-1:0]  sweep_q, sweep_d;
    logic [HIST_WIDTH-1:0] hist_q, hist_d;
    logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
    logic [OCC_W-1:0]      occ_q, occ_d;
    logic                  mis_q, mis_d;
    logic                  err_q, err_d;

    logic [IDX_WIDTH-1:0]  fetch_idx_c;
    logic [CNT_WIDTH-1:0]  pred_cnt_c;
    logic [CNT_WIDTH-1:0]  upd_cnt_c;
    entry_t                head_e_c;
    logic                  ready_c;
    logic                  pop_c;
    logic                  mis_now_c;
    logic                  accept_c;
    logic                  wr_en_c;
    logic [IDX_WIDTH-1:0]  wr_idx_c;
    logic [CNT_WIDTH-1:0]  wr_cnt_c;
    logic                  unused_c;

    // Fetch index, asynchronous table read and resolve qualification.
    always_comb begin
        fetch_idx_c = bus.fetch_pc[IDX_WIDTH+1:2];
        if (HASH_MODE != 0) begin
            fetch_idx_c = fetch_idx_c ^ IDX_WIDTH'(hist_q);
        end
        pred_cnt_c = table_q[fetch_idx_c];
        head_e_c   = queue_q[head_q];
        ready_c    = (state_q == ST_RUN) && (occ_q < OCC_W'(MAX_INFLIGHT));
        pop_c      = (state_q == ST_RUN) && bus.resolve_valid && (occ_q != '0);
        mis_now_c  = pop_c && (bus.resolve_taken != head_e_c.cnt[CNT_WIDTH-1]);
        accept_c   = bus.fetch_valid && ready_c && !bus.stall && !mis_now_c;
    end

    // Saturating training value for the resolving entry.
    always_comb begin
        upd_cnt_c = head_e_c.cnt;
        if (bus.resolve_taken) begin
            if (head_e_c.cnt != CNT_MAX) upd_cnt_c = head_e_c.cnt + CNT_WIDTH'(1);
        end else begin
            if (head_e_c.cnt != '0) upd_cnt_c = head_e_c.cnt - CNT_WIDTH'(1);
        end
    end

    // Next-state logic: init sweep, then speculative push / in-order resolve.
    always_comb begin
        state_d  = state_q;
        sweep_d  = sweep_q;
        hist_d   = hist_q;
        head_d   = head_q;
        tail_d   = tail_q;
        occ_d    = occ_q;
        mis_d    = 1'b0;
        err_d    = err_q;
        wr_en_c  = 1'b0;
        wr_idx_c = sweep_q;
        wr_cnt_c = CNT_WIDTH'(CNT_INIT);

        case (state_q)
            ST_INIT: begin
                wr_en_c = 1'b1;
                sweep_d = sweep_q + IDX_WIDTH'(1);
                if (sweep_q == SWEEP_LAST) state_d = ST_RUN;
            end
            ST_RUN: begin
                mis_d = mis_now_c;
                if (bus.resolve_valid && (occ_q == '0)) err_d = 1'b1;
                if (pop_c) begin
                    wr_en_c  = 1'b1;
                    wr_idx_c = head_e_c.idx;
                    wr_cnt_c = upd_cnt_c;
                end
                if (mis_now_c) begin
                    // Rebuild history from the snapshot taken when the branch was fetched.
                    hist_d = {head_e_c.hist[HIST_WIDTH-2:0], bus.resolve_taken};
                    head_d = '0;
                    tail_d = '0;
                    occ_d  = '0;
                end else begin
                    if (accept_c) begin
                        hist_d = {hist_q[HIST_WIDTH-2:0], pred_cnt_c[CNT_WIDTH-1]};
                        tail_d = tail_q + PTR_W'(1);
                    end
                    if (pop_c) head_d = head_q + PTR_W'(1);
                    occ_d = occ_q + OCC_W'(accept_c) - OCC_W'(pop_c);
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            sweep_q <= '0;
            hist_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            occ_q   <= '0;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            hist_q  <= hist_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            occ_q   <= occ_d;
            mis_q   <= mis_d;
            err_q   <= err_d;
        end
    end

    // Counter table and in-flight queue storage; contents are set by the sweep/pushes.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en_c) begin
            table_q[wr_idx_c] <= wr_cnt_c;
        end
        if (rst_n && accept_c) begin
            queue_q[tail_q] <= '{idx: fetch_idx_c, cnt: pred_cnt_c, hist: hist_q};
        end
    end

    assign bus.ready         = ready_c;
    assign bus.pred_count    = pred_cnt_c;
    assign bus.pred_taken    = pred_cnt_c[CNT_WIDTH-1];
    assign bus.mispredict    = mis_q;
    assign bus.inflight      = occ_q;
    assign bus.err_underflow = err_q;

    assign unused_c = ^{bus.fetch_pc[31:IDX_WIDTH+2], bus.fetch_pc[1:0],
                        head_e_c.hist[HIST_WIDTH-1]};

endmodule

// File: tb/tb_gshare_inflight_predictor.sv
// Bench: a bimodal and a gshare instance share directed stimulus and are
// checked every cycle against an array/queue-level model plus literal expectations.
module tb_gshare_inflight_predictor;

    localparam int CW = 2;
    localparam int IW = 4;
    localparam int HW = 4;
    localparam int MI = 4;
    localparam int OW = 3;
    localparam int NT = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        fv = 1'b0;
    logic [31:0] pc = '0;
    logic        rv = 1'b0;
    logic        rt = 1'b0;

    always #5 clk = ~clk;

    gshare_inflight_predictor_if #(.CNT_WIDTH(CW), .OCC_WIDTH(OW)) bus0 ();
    gshare_inflight_predictor_if #(.CNT_WIDTH(CW), .OCC_WIDTH(OW)) bus1 ();

    assign bus0.stall = stall;  assign bus1.stall = stall;
    assign bus0.fetch_valid = fv;  assign bus1.fetch_valid = fv;
    assign bus0.fetch_pc = pc;  assign bus1.fetch_pc = pc;
    assign bus0.resolve_valid = rv;  assign bus1.resolve_valid = rv;
    assign bus0.resolve_taken = rt;  assign bus1.resolve_taken = rt;

    gshare_inflight_predictor #(.CNT_WIDTH(CW), .CNT_INIT(1), .IDX_WIDTH(IW), .HIST_WIDTH(HW),
        .HASH_MODE(0), .MAX_INFLIGHT(MI)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    gshare_inflight_predictor #(.CNT_WIDTH(CW), .CNT_INIT(1), .IDX_WIDTH(IW), .HIST_WIDTH(HW),
        .HASH_MODE(1), .MAX_INFLIGHT(MI)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    logic          o_ready [2];
    logic          o_pt    [2];
    logic [CW-1:0] o_cnt   [2];
    logic          o_mis   [2];
    logic [OW-1:0] o_inf   [2];
    logic          o_err   [2];

    assign o_ready[0] = bus0.ready;       assign o_ready[1] = bus1.ready;
    assign o_pt[0]    = bus0.pred_taken;  assign o_pt[1]    = bus1.pred_taken;
    assign o_cnt[0]   = bus0.pred_count;  assign o_cnt[1]   = bus1.pred_count;
    assign o_mis[0]   = bus0.mispredict;  assign o_mis[1]   = bus1.mispredict;
    assign o_inf[0]   = bus0.inflight;    assign o_inf[1]   = bus1.inflight;
    assign o_err[0]   = bus0.err_underflow; assign o_err[1] = bus1.err_underflow;

    int errors = 0;
    int checks = 0;

    task automatic check(input string nm, input int m, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, m, got, exp, $time);
        end
    endtask

    // Model: whole-table array, list of outstanding predictions, integer history.
    typedef struct {
        int idx;
        int cnt;
        int hist;
    } ent_t;

    int   m_tab  [2][NT];
    ent_t m_q    [2][MI];
    int   m_n    [2];
    int   m_hist [2];
    int   m_ptr  [2];
    bit   m_run  [2];
    bit   m_mis  [2];
    bit   m_err  [2];
    bit   known = 1'b0;

    function automatic int m_idx(input int m);
        int base;
        base = int'(pc >> 2) % NT;
        return (m == 1) ? (base ^ m_hist[m]) : base;
    endfunction

    task automatic model_step(input int m);
        int   idx, cnt, nc;
        bit   had, mis_now, acc;
        ent_t h;
        if (!rst_n) begin
            m_run[m] = 0; m_ptr[m] = 0; m_hist[m] = 0; m_n[m] = 0;
            m_mis[m] = 0; m_err[m] = 0;
        end else if (!m_run[m]) begin
            m_tab[m][m_ptr[m]] = 1;
            m_mis[m] = 0;
            if (m_ptr[m] == NT - 1) m_run[m] = 1;
            m_ptr[m] = (m_ptr[m] + 1) % NT;
        end else begin
            idx = m_idx(m);
            cnt = m_tab[m][idx];
            had = m_n[m] > 0;
            h   = m_q[m][0];
            mis_now = rv && had && (rt != (h.cnt >= 2));
            acc = fv && (m_n[m] < MI) && !stall && !mis_now;
            m_mis[m] = mis_now;
            if (rv && !had) m_err[m] = 1;
            if (rv && had) begin
                nc = rt ? h.cnt + 1 : h.cnt - 1;
                if (nc > 3) nc = 3;
                if (nc < 0) nc = 0;
                m_tab[m][h.idx] = nc;
                for (int k = 0; k < MI - 1; k++) m_q[m][k] = m_q[m][k+1];
                m_n[m]--;
                if (mis_now) begin
                    m_hist[m] = (h.hist * 2 + int'(rt)) % NT;
                    m_n[m] = 0;
                end
            end
            if (acc) begin
                m_q[m][m_n[m]] = '{idx, cnt, m_hist[m]};
                m_n[m]++;
                m_hist[m] = (m_hist[m] * 2 + ((cnt >= 2) ? 1 : 0)) % NT;
            end
        end
    endtask

    // Per-cycle comparison against the model, then advance the model one edge.
    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (known) begin
                check("ready", m, o_ready[m], (m_run[m] && m_n[m] < MI) ? 1 : 0);
                check("inflight", m, o_inf[m], m_n[m]);
                check("mispredict", m, o_mis[m], m_mis[m]);
                check("err_underflow", m, o_err[m], m_err[m]);
                if (m_run[m]) begin
                    check("pred_count", m, o_cnt[m], m_tab[m][m_idx(m)]);
                    check("pred_taken", m, o_pt[m], (m_tab[m][m_idx(m)] >= 2) ? 1 : 0);
                end
            end
            model_step(m);
        end
        if (!rst_n) known = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_and_init();
        fv = 0; rv = 0; rt = 0; stall = 0; pc = '0;
        rst_n = 0;
        tick(); tick();
        rst_n = 1;
        repeat (16) tick();
    endtask

    task automatic fetch_then_resolve(input logic [31:0] a, input logic t);
        pc = a; fv = 1; tick();
        fv = 0; rv = 1; rt = t; tick();
        rv = 0;
    endtask

    int exp_up [4] = '{1, 2, 3, 3};
    int exp_dn [4] = '{3, 2, 1, 0};
    logic [31:0] pcs [4] = '{32'h0, 32'h44, 32'h3C, 32'hFFFC};

    initial begin
        // Init sweep with a reset in the middle.
        tick(); tick();
        rst_n = 1;
        repeat (8) tick();
        check("ready_mid_sweep", 0, o_ready[0], 0);
        rst_n = 0; tick(); rst_n = 1;
        repeat (15) tick();
        check("ready_before_done", 0, o_ready[0], 0);
        check("ready_before_done", 1, o_ready[1], 0);
        tick();
        check("ready_after_sweep", 0, o_ready[0], 1);
        check("ready_after_sweep", 1, o_ready[1], 1);
        for (int i = 0; i < 4; i++) begin
            pc = pcs[i]; #1;
            check("init_count", 0, o_cnt[0], 1);
            check("init_count", 1, o_cnt[1], 1);
            check("init_taken", 0, o_pt[0], 0);
        end

        // Bimodal saturation at pc 0x40.
        for (int i = 0; i < 4; i++) begin
            pc = 32'h40; fv = 1; #1;
            check("sat_up", 0, o_cnt[0], exp_up[i]);
            check("sat_up_taken", 0, o_pt[0], (exp_up[i] >= 2) ? 1 : 0);
            tick();
            fv = 0; rv = 1; rt = 1; tick(); rv = 0;
        end
        for (int i = 0; i < 4; i++) begin
            pc = 32'h40; fv = 1; #1;
            check("sat_down", 0, o_cnt[0], exp_dn[i]);
            tick();
            fv = 0; rv = 1; rt = 0; tick(); rv = 0;
        end
        #1;
        check("sat_floor", 0, o_cnt[0], 0);

        // Gshare: steer history to 4'b0101, then look up pc 0x100.
        reset_and_init();
        fetch_then_resolve(32'h0, 1);
        fetch_then_resolve(32'h0, 0);
        fetch_then_resolve(32'h0, 1);
        pc = 32'h14; #1;
        check("gs_hist_0101", 1, o_cnt[1], 2);
        pc = 32'h100; #1;
        check("gs_idx5_count", 1, o_cnt[1], 1);
        check("gs_idx5_taken", 1, o_pt[1], 0);
        fv = 1; tick(); fv = 0;
        pc = 32'h28; #1;
        check("gs_hist_1010", 1, o_cnt[1], 2);
        check("gs_inflight", 1, o_inf[1], 1);
        rv = 1; rt = 0; tick(); rv = 0;

        // Mispredict flush with a concurrent fetch.
        reset_and_init();
        fv = 1;
        pc = 32'h0; tick();
        pc = 32'h4; tick();
        pc = 32'h8; tick();
        check("flush_fill", 0, o_inf[0], 3);
        check("flush_fill", 1, o_inf[1], 3);
        pc = 32'h0; rv = 1; rt = 1; tick();
        fv = 0; rv = 0;
        check("flush_pulse", 0, o_mis[0], 1);
        check("flush_pulse", 1, o_mis[1], 1);
        check("flush_empty", 0, o_inf[0], 0);
        check("flush_empty", 1, o_inf[1], 0);
        tick();
        check("flush_pulse_end", 1, o_mis[1], 0);
        pc = 32'h4; #1;
        check("flush_hist", 1, o_cnt[1], 2);
        pc = 32'h0; #1;
        check("flush_hist_other", 1, o_cnt[1], 1);
        check("flush_trained", 0, o_cnt[0], 2);

        // Full queue blocks a fetch even with a correct resolve in the same cycle.
        reset_and_init();
        fv = 1;
        for (int i = 0; i < 4; i++) begin
            pc = 32'(i * 4); tick();
        end
        fv = 0; #1;
        check("full_ready", 0, o_ready[0], 0);
        check("full_inflight", 1, o_inf[1], 4);
        pc = 32'h10; fv = 1; rv = 1; rt = 0; #1;
        check("full_no_bypass", 1, o_ready[1], 0);
        tick();
        fv = 0; rv = 0;
        check("full_pop_only", 0, o_inf[0], 3);
        check("full_pop_only", 1, o_inf[1], 3);
        check("full_ready_again", 1, o_ready[1], 1);
        rv = 1; rt = 0; repeat (3) tick(); rv = 0;

        // Underflow is sticky and leaves the table alone; stall blocks push but not pop.
        rv = 1; rt = 1; tick(); rv = 0;
        check("underflow", 0, o_err[0], 1);
        check("underflow", 1, o_err[1], 1);
        pc = 32'h0; #1;
        check("underflow_no_write", 0, o_cnt[0], 0);
        repeat (3) tick();
        check("underflow_sticky", 1, o_err[1], 1);
        pc = 32'h20; fv = 1; tick();
        stall = 1; rv = 1; rt = 0; tick();
        stall = 0; fv = 0; rv = 0;
        check("stall_pop", 0, o_inf[0], 0);
        check("stall_pop", 1, o_inf[1], 0);
        rst_n = 0; tick(); rst_n = 1;
        check("reset_err_clear", 0, o_err[0], 0);
        check("reset_ready", 1, o_ready[1], 0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
